// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game: FSM encoding and default
// timing/width constants used by the meter and the display block.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DELAY = 2'd1,
    MEASURE    = 2'd2,
    HOLD       = 2'd3
  } state_t;

  localparam int DEF_CLKS_PER_MS  = 50000;
  localparam int DISPLAY_RESULT_W = 14;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLKS_PER_MS clocks, restartable
// by a synchronous clear so the first tick lands CLKS_PER_MS cycles later.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_W'(CLKS_PER_MS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_meter.sv
// Reaction-time meter: after a fixed delay lights the stimulus, then counts ms
// until the button's rising edge and offers the result on a valid/ready port.
module reaction_meter
  import reaction_pkg::*;
#(
  parameter int CLKS_PER_MS = DEF_CLKS_PER_MS,
  parameter int DELAY_MS    = 2000,
  parameter int MAX_MS      = 9999,
  parameter int RESULT_W    = DISPLAY_RESULT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                button,
  output logic                led_on,
  output logic [RESULT_W-1:0] result_ms,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                early,
  output logic                timeout
);

  localparam int DLY_W = $clog2(DELAY_MS + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_button_q;
  logic [DLY_W-1:0]    r_dly_cnt;
  logic [RESULT_W-1:0] r_ms_cnt;
  logic [RESULT_W-1:0] r_result_ms;
  logic                r_early;
  logic                r_timeout;

  logic w_tick;
  logic w_press;
  logic w_entry;
  logic w_delay_done;
  logic w_saturate;

  assign w_press      = button & ~r_button_q;
  assign w_entry      = (w_state_nxt != r_state);
  assign w_delay_done = w_tick && (r_dly_cnt == DLY_W'(DELAY_MS - 1));
  assign w_saturate   = w_tick && (r_ms_cnt == RESULT_W'(MAX_MS - 1));

  // Restarted on every state change so each phase starts on a full millisecond.
  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(w_entry),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (start) w_state_nxt = WAIT_DELAY;
      WAIT_DELAY: begin
        if (w_press)           w_state_nxt = HOLD;
        else if (w_delay_done) w_state_nxt = MEASURE;
      end
      MEASURE:    if (w_press || w_saturate) w_state_nxt = HOLD;
      HOLD:       if (result_ready) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    led_on       = (r_state == MEASURE);
    result_valid = (r_state == HOLD);
    result_ms    = r_result_ms;
    early        = r_early;
    timeout      = r_timeout;
  end

  // Press beats a coincident final/saturating tick, so press is tested first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_button_q  <= 1'b0;
      r_dly_cnt   <= '0;
      r_ms_cnt    <= '0;
      r_result_ms <= '0;
      r_early     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_button_q <= button;

      if (w_entry) begin
        r_dly_cnt <= '0;
        r_ms_cnt  <= '0;
      end else if (w_tick) begin
        if (r_state == WAIT_DELAY) r_dly_cnt <= r_dly_cnt + 1'b1;
        if (r_state == MEASURE)    r_ms_cnt  <= r_ms_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_early   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        WAIT_DELAY: begin
          if (w_press) begin
            r_early     <= 1'b1;
            r_result_ms <= '0;
          end
        end
        MEASURE: begin
          if (w_press) begin
            r_result_ms <= r_ms_cnt;
          end else if (w_saturate) begin
            r_result_ms <= RESULT_W'(MAX_MS);
            r_timeout   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_meter.sv
// Directed bench for reaction_meter with CLKS_PER_MS=4, DELAY_MS=3, MAX_MS=10:
// normal, early, timeout, held-button, coincident-tick, backpressure, async reset.
module tb_reaction_meter;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          button;
  logic          led_on;
  logic [RW-1:0] result_ms;
  logic          result_valid;
  logic          result_ready;
  logic          early;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  reaction_meter #(
    .CLKS_PER_MS(4),
    .DELAY_MS   (3),
    .MAX_MS     (10),
    .RESULT_W   (RW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .button      (button),
    .led_on      (led_on),
    .result_ms   (result_ms),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .early       (early),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic l, input logic [RW-1:0] r,
                            input logic v, input logic e, input logic t);
    check({tag, ".led_on"},       {31'd0, led_on},       {31'd0, l});
    check({tag, ".result_ms"},    {28'd0, result_ms},    {28'd0, r});
    check({tag, ".result_valid"}, {31'd0, result_valid}, {31'd0, v});
    check({tag, ".early"},        {31'd0, early},        {31'd0, e});
    check({tag, ".timeout"},      {31'd0, timeout},      {31'd0, t});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; button = 1'b0; result_ready = 1'b0;
    step(3);
    check_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(2);

    // Normal trial: led_on 12 cycles after entry, press after 5 ms.
    start = 1'b1; step(1); start = 1'b0;
    step(11);
    check("norm.led_before", {31'd0, led_on}, 32'd0);
    step(1);
    check("norm.led_rise", {31'd0, led_on}, 32'd1);
    step(21);
    check("norm.valid_before", {31'd0, result_valid}, 32'd0);
    button = 1'b1; step(1);
    check_outs("norm.press", 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    button = 1'b0; result_ready = 1'b1; step(1); result_ready = 1'b0;
    check("norm.accept_valid", {31'd0, result_valid}, 32'd0);
    check("norm.keep_ms", {28'd0, result_ms}, 32'd5);
    step(2);

    // Early press 5 cycles into the delay.
    start = 1'b1; step(1); start = 1'b0;
    step(4);
    button = 1'b1; step(1);
    check_outs("early.press", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    step(20);
    check_outs("early.hold", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    button = 1'b0; result_ready = 1'b1; step(1); result_ready = 1'b0;
    check("early.accept", {31'd0, result_valid}, 32'd0);
    step(2);

    // Timeout: no press at all.
    start = 1'b1; step(1); start = 1'b0;
    check("to.early_cleared", {31'd0, early}, 32'd0);
    step(12);
    check("to.led_rise", {31'd0, led_on}, 32'd1);
    step(39);
    check_outs("to.before", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_outs("to.expire", 1'b0, 4'd10, 1'b1, 1'b0, 1'b1);
    result_ready = 1'b1; step(1); result_ready = 1'b0;
    step(2);

    // Button held high before and throughout the trial is never a press.
    button = 1'b1; step(3);
    start = 1'b1; step(1); start = 1'b0;
    check("held.no_early", {31'd0, result_valid}, 32'd0);
    step(12);
    check("held.led_rise", {31'd0, led_on}, 32'd1);
    step(40);
    check_outs("held.timeout", 1'b0, 4'd10, 1'b1, 1'b0, 1'b1);
    button = 1'b0; result_ready = 1'b1; step(1); result_ready = 1'b0;
    step(2);

    // Press coincident with the saturating 10th tick: press wins, pre-tick count.
    start = 1'b1; step(1); start = 1'b0;
    step(12);
    check("coin.led_rise", {31'd0, led_on}, 32'd1);
    step(39);
    button = 1'b1; step(1);
    check_outs("coin.press", 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);

    // Backpressure: presses and starts in HOLD change nothing.
    for (int i = 0; i < 100; i++) begin
      button = i[0];
      start  = (i % 7 == 3);
      step(1);
      check("bp.valid", {31'd0, result_valid}, 32'd1);
      check("bp.ms", {28'd0, result_ms}, 32'd9);
    end
    check_outs("bp.end", 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
    button = 1'b0;
    start = 1'b1; result_ready = 1'b1; step(1);
    start = 1'b0; result_ready = 1'b0;
    check("bp.accept", {31'd0, result_valid}, 32'd0);
    step(15);
    check("bp.start_dropped_led", {31'd0, led_on}, 32'd0);
    check("bp.start_dropped_valid", {31'd0, result_valid}, 32'd0);

    // Asynchronous reset in the middle of MEASURE.
    start = 1'b1; step(1); start = 1'b0;
    step(17);
    check("rst.in_measure", {31'd0, led_on}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_outs("rst.async", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(2);
    #3 reset = 1'b0;
    step(2);
    button = 1'b1; step(1);
    step(20);
    check("rst.no_valid", {31'd0, result_valid}, 32'd0);
    check("rst.no_led", {31'd0, led_on}, 32'd0);
    button = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
